godai_trace_recorder: RTL
=========================

GODAI_TRACE_RECORDER -- requirements
Module: godai_trace_recorder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, number of buffered records; power of two, 4..256.
REQ-002 SHALL have parameter TS_WIDTH, default 22, timestamp width; record width RW = TS_WIDTH+10 (32 at default).
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port enable_i  input  1  capture enable.
REQ-006 SHALL have port clear_i  input  1  synchronous flush.
REQ-007 SHALL have ports if_busy_i, if_ready_i, id_ready_i, is_decoding_i, jump_done_i, data_req_id_i, ex_ready_i, wb_ready_i, illegal_instr_i  input  1 each  core pipeline trace events, packed as event vector bits [0]..[8] in that order.
REQ-008 SHALL have port trace_valid_o  output  1  head record available.
REQ-009 SHALL have port trace_ready_i  input  1  consumer accepts head record.
REQ-010 SHALL have port trace_data_o  output  RW  head record: [RW-1] overflow flag, [RW-2:9] timestamp, [8:0] event vector.
REQ-011 SHALL have port fifo_level_o  output  clog2(FIFO_DEPTH)+1  records stored.
REQ-012 SHALL have port drop_count_o  output  16  records dropped.

Function
REQ-013 SHALL run a free-running timestamp counter, +1 per cycle, wrapping from 2^TS_WIDTH-1 to 0.
REQ-014 SHALL register the 9-bit event vector and current timestamp at each edge (stage S1); the record formed from inputs sampled at edge E0 carries the counter value held before E0.
REQ-015 SHALL write a captured record into the FIFO at the edge following S1 capture (E1); trace_valid_o rises in the cycle after E1 when the FIFO was empty, i.e. 2-cycle input-to-valid latency.
REQ-016 SHALL capture a record only when enable_i is high at the sampling edge (capture rule per REQ-029/030).
REQ-017 SHALL present the FIFO head first-word-fall-through; a pop occurs on an edge where trace_valid_o && trace_ready_i.
REQ-018 SHALL drive trace_data_o to all zeros while trace_valid_o is low.
REQ-019 SHALL hold trace_data_o and trace_valid_o stable while trace_valid_o && !trace_ready_i.
REQ-020 SHALL accept a write when FIFO not full, or full with a pop on the same edge (level unchanged).
REQ-021 SHALL, when full and no pop, drop the record, increment drop_count_o saturating at 16'hFFFF, and set a sticky overflow flag.
REQ-022 SHALL place the overflow flag in bit [RW-1] of the next successfully written record and clear the flag on that same edge.
REQ-023 SHALL allow simultaneous push and pop on an empty FIFO only through write-then-read: a record written at edge E is not poppable before the cycle after E.
REQ-024 SHALL, on clear_i high, on that edge empty the FIFO, zero timestamp, drop_count_o, overflow flag, S1 stage and comparison register; clear_i has priority over push and pop.

Reset
REQ-025 SHALL, with rst_n low at an edge, set timestamp, FIFO pointers, fifo_level_o, drop_count_o, overflow flag, S1 stage and last-event register to zero.
REQ-026 SHALL output trace_valid_o=0, trace_data_o=0, fifo_level_o=0, drop_count_o=0 during and after reset.
REQ-027 SHALL discard any in-flight S1 record when reset asserts mid-operation; first capture after reset is treated as first-after-enable.
REQ-028 SHALL take rst_n priority over clear_i.

Configuration
REQ-029 SHALL, with macro GODAI_TRACE_COMPRESS_EN defined, capture only when the event vector differs from the last captured vector, or on the first enabled cycle after reset, clear_i, or a 0->1 edge of enable_i.
REQ-030 SHALL, without GODAI_TRACE_COMPRESS_EN, capture every cycle enable_i is high; no last-event register is built.

Structure
REQ-031 SHALL take event bit indices, record field offsets and TS_WIDTH/FIFO_DEPTH defaults from shared package godai_trace_pkg.
REQ-032 SHALL instantiate one sub-module godai_trace_fifo (synchronous FWFT FIFO, parameter width/depth, level output).

Verification
REQ-033 SHALL verify reset: rst_n low 3 cycles with events toggling -> valid=0, data=0, level=0, drop=0.
REQ-034 SHALL verify latency: enable=1, ready=1, if_ready pulse at edge with timestamp 5 -> valid 2 cycles later, data[8:0]=9'h002, timestamp=5.
REQ-035 SHALL verify overflow: ready=0, FIFO_DEPTH=16, no compression, 20 enabled cycles -> level=16, drop=4; then ready=1 -> next written record bit[31]=1, subsequent record bit[31]=0.
REQ-036 SHALL verify full push+pop: FIFO full, ready=1 with new capture -> level stays 16, drop unchanged.
REQ-037 SHALL verify compression (macro on): constant events 10 cycles then illegal_instr_i=1 -> exactly 2 records, second data[8]=1.
REQ-038 SHALL verify clear and wrap: TS_WIDTH=4, run 17 cycles -> timestamps wrap 15->0; clear_i mid-stream -> level=0, drop=0, next record timestamp restarts at 0.

Source files
------------

// File: rtl/godai_trace_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | godai_trace_pkg : shared event indices, record layout and defaults    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package godai_trace_pkg;

  localparam int EV_WIDTH         = 9;
  localparam int EV_IF_BUSY       = 0;
  localparam int EV_IF_READY      = 1;
  localparam int EV_ID_READY      = 2;
  localparam int EV_IS_DECODING   = 3;
  localparam int EV_JUMP_DONE     = 4;
  localparam int EV_DATA_REQ_ID   = 5;
  localparam int EV_EX_READY      = 6;
  localparam int EV_WB_READY      = 7;
  localparam int EV_ILLEGAL_INSTR = 8;

  // Record layout: {overflow, timestamp, event vector}
  localparam int REC_EV_LSB = 0;
  localparam int REC_TS_LSB = EV_WIDTH;

  localparam int TS_WIDTH_DEF   = 22;
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int DROP_WIDTH     = 16;

  typedef logic [EV_WIDTH-1:0] ev_vec_t;

  function automatic logic [DROP_WIDTH-1:0] sat_inc16(input logic [DROP_WIDTH-1:0] v);
    return (v == {DROP_WIDTH{1'b1}}) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/godai_trace_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | godai_trace_fifo : synchronous first-word-fall-through record FIFO    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module godai_trace_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             pop_ok;
  logic             push_ok;

  assign valid_o = (level_q != '0);
  assign full_o  = (level_q == FULL_LVL);
  assign pop_ok  = pop_i && valid_o;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign push_ok = push_i && (!full_o || pop_ok);

  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + LW'(push_ok) - LW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !clear_i && push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;
  assign level_o = level_q;

endmodule
`default_nettype wire

// File: rtl/godai_trace_recorder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | godai_trace_recorder : timestamped pipeline-event trace buffer        |
// | Option macro GODAI_TRACE_COMPRESS_EN : record only changed vectors    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module godai_trace_recorder
  import godai_trace_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int TS_WIDTH   = TS_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable_i,
  input  logic                          clear_i,
  input  logic                          if_busy_i,
  input  logic                          if_ready_i,
  input  logic                          id_ready_i,
  input  logic                          is_decoding_i,
  input  logic                          jump_done_i,
  input  logic                          data_req_id_i,
  input  logic                          ex_ready_i,
  input  logic                          wb_ready_i,
  input  logic                          illegal_instr_i,
  output logic                          trace_valid_o,
  input  logic                          trace_ready_i,
  output logic [TS_WIDTH+9:0]           trace_data_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic [DROP_WIDTH-1:0]         drop_count_o
);

  localparam int RW = TS_WIDTH + 10;

  ev_vec_t               ev_d;
  logic [TS_WIDTH-1:0]   ts_q;
  logic                  s1_vld_q;
  ev_vec_t               s1_ev_q;
  logic [TS_WIDTH-1:0]   s1_ts_q;
  logic                  ovf_q;
  logic [DROP_WIDTH-1:0] drop_q;
  logic                  capture;
  logic                  fifo_valid;
  logic                  fifo_full;
  logic                  pop;
  logic                  push;
  logic                  drop;
  logic [RW-1:0]         rec_d;

  always_comb begin
    ev_d                   = '0;
    ev_d[EV_IF_BUSY]       = if_busy_i;
    ev_d[EV_IF_READY]      = if_ready_i;
    ev_d[EV_ID_READY]      = id_ready_i;
    ev_d[EV_IS_DECODING]   = is_decoding_i;
    ev_d[EV_JUMP_DONE]     = jump_done_i;
    ev_d[EV_DATA_REQ_ID]   = data_req_id_i;
    ev_d[EV_EX_READY]      = ex_ready_i;
    ev_d[EV_WB_READY]      = wb_ready_i;
    ev_d[EV_ILLEGAL_INSTR] = illegal_instr_i;
  end

`ifdef GODAI_TRACE_COMPRESS_EN
  logic    last_vld_q;
  ev_vec_t last_ev_q;

  // last_vld_q drops whenever enable is low, so a rising enable forces a capture.
  assign capture = enable_i && (!last_vld_q || (ev_d != last_ev_q));

  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      last_vld_q <= 1'b0;
      last_ev_q  <= '0;
    end else if (!enable_i) begin
      last_vld_q <= 1'b0;
    end else if (capture) begin
      last_vld_q <= 1'b1;
      last_ev_q  <= ev_d;
    end
  end
`else
  assign capture = enable_i;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      ts_q     <= '0;
      s1_vld_q <= 1'b0;
      s1_ev_q  <= '0;
      s1_ts_q  <= '0;
    end else begin
      ts_q     <= ts_q + TS_WIDTH'(1);
      s1_vld_q <= capture;
      s1_ev_q  <= ev_d;
      s1_ts_q  <= ts_q;
    end
  end

  assign pop  = fifo_valid && trace_ready_i;
  assign push = s1_vld_q && (!fifo_full || pop);
  assign drop = s1_vld_q && fifo_full && !pop;

  always_comb begin
    rec_d                              = '0;
    rec_d[REC_EV_LSB +: EV_WIDTH]      = s1_ev_q;
    rec_d[REC_TS_LSB +: TS_WIDTH]      = s1_ts_q;
    rec_d[RW-1]                        = ovf_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else if (drop) begin
      ovf_q  <= 1'b1;
      drop_q <= sat_inc16(drop_q);
    end else if (push) begin
      ovf_q  <= 1'b0;
    end
  end

  godai_trace_fifo #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (rec_d),
    .rdata_o (trace_data_o),
    .valid_o (fifo_valid),
    .full_o  (fifo_full),
    .level_o (fifo_level_o)
  );

  assign trace_valid_o = fifo_valid;
  assign drop_count_o  = drop_q;

endmodule
`default_nettype wire
